// File: rtl/clock_pkg.sv
// Shared time-of-day constants and the 24h -> 12h hour mapping used by the
// time counter and the display formatter.
package clock_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef struct packed {
        logic       pm;
        logic [3:0] hour12;
    } hour12_t;

    function automatic hour12_t to_12h(input logic [HOUR_W-1:0] h);
        hour12_t r;
        r.pm = (h >= 5'd12);
        if (h == 5'd0) begin
            r.hour12 = 4'd12;
        end else if (h <= 5'd12) begin
            r.hour12 = h[3:0];
        end else begin
            r.hour12 = 4'(h - 5'd12);
        end
        return r;
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-(MAX+1) counter with synchronous load; wrap is combinational so
// stages can be chained in the same clock.
module mod_n_counter #(
    parameter int unsigned    W       = 6,
    parameter logic [W-1:0]   MAX     = '1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         wrap
);

    logic at_max_s;

    assign at_max_s = (value == MAX);
    assign wrap     = inc & at_max_s;

    // Counter state: load wins over increment; wraps to zero after MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= at_max_s ? {W{1'b0}} : value + W'(1);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/time_counter.sv
// Hour/minute/second time-of-day counter with validated adjust load and
// registered carry pulses. Optional 12-hour outputs under TIME_12H_EN.
module time_counter
    import clock_pkg::*;
#(
    parameter int unsigned RST_HOUR = 0,
    parameter int unsigned RST_MIN  = 0,
    parameter int unsigned RST_SEC  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              adjust_mode,
    input  logic [HOUR_W-1:0] adj_hour,
    input  logic [MIN_W-1:0]  adj_min,
    input  logic [SEC_W-1:0]  adj_sec,
    output logic [SEC_W-1:0]  second,
    output logic [MIN_W-1:0]  minute,
    output logic [HOUR_W-1:0] hour,
    output logic              carry_min,
    output logic              carry_hour,
    output logic              carry_day,
    output logic              adj_error
`ifdef TIME_12H_EN
    ,
    output logic [3:0]        hour12,
    output logic              pm
`endif
);

    localparam logic [HOUR_W-1:0] RST_H = HOUR_W'(RST_HOUR);
    localparam logic [MIN_W-1:0]  RST_M = MIN_W'(RST_MIN);
    localparam logic [SEC_W-1:0]  RST_S = SEC_W'(RST_SEC);

    if (RST_HOUR > 32'd23) begin : g_bad_rst_hour
        $error("time_counter: RST_HOUR out of range");
    end
    if (RST_MIN > 32'd59) begin : g_bad_rst_min
        $error("time_counter: RST_MIN out of range");
    end
    if (RST_SEC > 32'd59) begin : g_bad_rst_sec
        $error("time_counter: RST_SEC out of range");
    end

    logic valid_s;
    logic load_s;
    logic inc_sec_s;
    logic sec_wrap_s;
    logic min_wrap_s;
    logic hour_wrap_s;

    assign valid_s   = (adj_hour <= HOUR_MAX) & (adj_min <= MIN_MAX) & (adj_sec <= SEC_MAX);
    // An invalid adjust holds all three counters: no partial loads.
    assign load_s    = adjust_mode & valid_s;
    assign inc_sec_s = ~adjust_mode & tick;

    mod_n_counter #(.W(SEC_W), .MAX(SEC_MAX), .RST_VAL(RST_S)) u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc_sec_s),
        .load     (load_s),
        .load_val (adj_sec),
        .value    (second),
        .wrap     (sec_wrap_s)
    );

    mod_n_counter #(.W(MIN_W), .MAX(MIN_MAX), .RST_VAL(RST_M)) u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_wrap_s),
        .load     (load_s),
        .load_val (adj_min),
        .value    (minute),
        .wrap     (min_wrap_s)
    );

    mod_n_counter #(.W(HOUR_W), .MAX(HOUR_MAX), .RST_VAL(RST_H)) u_hour (
        .clk      (clk),
        .rst      (rst),
        .inc      (min_wrap_s),
        .load     (load_s),
        .load_val (adj_hour),
        .value    (hour),
        .wrap     (hour_wrap_s)
    );

    // Carry pulses line up with the counter values they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_min  <= 1'b0;
            carry_hour <= 1'b0;
            carry_day  <= 1'b0;
        end else begin
            carry_min  <= sec_wrap_s;
            carry_hour <= min_wrap_s;
            carry_day  <= hour_wrap_s;
        end
    end

    // Adjust error flag: updated on every adjust cycle, otherwise sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adj_error <= 1'b0;
        end else if (adjust_mode) begin
            adj_error <= ~valid_s;
        end else begin
            adj_error <= adj_error;
        end
    end

`ifdef TIME_12H_EN
    localparam hour12_t RST_12 = to_12h(RST_H);

    logic [HOUR_W-1:0] hour_next_s;

    // Next hour value, so the 12h view registers in step with hour.
    always_comb begin
        hour_next_s = hour;
        if (load_s) begin
            hour_next_s = adj_hour;
        end else if (min_wrap_s) begin
            hour_next_s = (hour == HOUR_MAX) ? 5'd0 : hour + 5'd1;
        end else begin
            hour_next_s = hour;
        end
    end

    // 12-hour display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pm     <= RST_12.pm;
            hour12 <= RST_12.hour12;
        end else begin
            {pm, hour12} <= to_12h(hour_next_s);
        end
    end
`endif

endmodule

// File: tb/tb_time_counter.sv
// Directed self-checking bench for time_counter (24h build; 12h checks
// are added when TIME_12H_EN is defined).
module tb_time_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       adjust_mode;
    logic [4:0] adj_hour;
    logic [5:0] adj_min;
    logic [5:0] adj_sec;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic       carry_min;
    logic       carry_hour;
    logic       carry_day;
    logic       adj_error;
`ifdef TIME_12H_EN
    logic [3:0] hour12;
    logic       pm;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    time_counter dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .adjust_mode (adjust_mode),
        .adj_hour    (adj_hour),
        .adj_min     (adj_min),
        .adj_sec     (adj_sec),
        .second      (second),
        .minute      (minute),
        .hour        (hour),
        .carry_min   (carry_min),
        .carry_hour  (carry_hour),
        .carry_day   (carry_day),
        .adj_error   (adj_error)
`ifdef TIME_12H_EN
        ,
        .hour12      (hour12),
        .pm          (pm)
`endif
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        adjust_mode = 1'b1;
        adj_hour    = h;
        adj_min     = m;
        adj_sec     = s;
        cycle();
        adjust_mode = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; adjust_mode = 1'b0;
        adj_hour = 5'd0; adj_min = 6'd0; adj_sec = 6'd0;
        #2;
        checks++;
        if ({hour, minute, second, carry_min, carry_hour, carry_day, adj_error} !== 21'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d:%0d:%0d c=%b%b%b err=%b, want 0:0:0 c=000 err=0",
                     hour, minute, second, carry_min, carry_hour, carry_day, adj_error);
        end
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if ({hour, minute, second, carry_min, carry_hour, carry_day, adj_error} !== 21'd0) begin
                failures++;
                $display("FAIL idle_hold[%0d]: got %0d:%0d:%0d c=%b%b%b, want 0:0:0 c=000",
                         i, hour, minute, second, carry_min, carry_hour, carry_day);
            end
        end
    endtask

    task automatic test_day_rollover();
        load_time(5'd23, 6'd59, 6'd58);
        checks++;
        if ({hour, minute, second, carry_min, carry_hour, carry_day} !== {5'd23, 6'd59, 6'd58, 3'b000}) begin
            failures++;
            $display("FAIL day_load: got %0d:%0d:%0d c=%b%b%b, want 23:59:58 c=000",
                     hour, minute, second, carry_min, carry_hour, carry_day);
        end
        do_tick();
        checks++;
        if ({hour, minute, second, carry_min, carry_hour, carry_day} !== {5'd23, 6'd59, 6'd59, 3'b000}) begin
            failures++;
            $display("FAIL day_tick1: got %0d:%0d:%0d c=%b%b%b, want 23:59:59 c=000",
                     hour, minute, second, carry_min, carry_hour, carry_day);
        end
        do_tick();
        checks++;
        if ({hour, minute, second, carry_min, carry_hour, carry_day} !== {5'd0, 6'd0, 6'd0, 3'b111}) begin
            failures++;
            $display("FAIL day_wrap: got %0d:%0d:%0d c=%b%b%b, want 0:0:0 c=111",
                     hour, minute, second, carry_min, carry_hour, carry_day);
        end
        cycle();
        checks++;
        if ({hour, minute, second, carry_min, carry_hour, carry_day} !== {5'd0, 6'd0, 6'd0, 3'b000}) begin
            failures++;
            $display("FAIL day_pulse_end: got %0d:%0d:%0d c=%b%b%b, want 0:0:0 c=000",
                     hour, minute, second, carry_min, carry_hour, carry_day);
        end
    endtask

    task automatic test_hour_carry();
        load_time(5'd10, 6'd59, 6'd59);
        do_tick();
        checks++;
        if ({hour, minute, second, carry_min, carry_hour, carry_day} !== {5'd11, 6'd0, 6'd0, 3'b110}) begin
            failures++;
            $display("FAIL hour_carry: got %0d:%0d:%0d c=%b%b%b, want 11:0:0 c=110",
                     hour, minute, second, carry_min, carry_hour, carry_day);
        end
        cycle();
        checks++;
        if ({carry_min, carry_hour, carry_day} !== 3'b000) begin
            failures++;
            $display("FAIL hour_pulse_end: got c=%b%b%b, want c=000", carry_min, carry_hour, carry_day);
        end
    endtask

    task automatic test_adjust_error();
        load_time(5'd12, 6'd34, 6'd56);
        adjust_mode = 1'b1; tick = 1'b1;
        adj_hour = 5'd24; adj_min = 6'd0; adj_sec = 6'd0;
        cycle();
        checks++;
        if ({hour, minute, second, adj_error} !== {5'd12, 6'd34, 6'd56, 1'b1}) begin
            failures++;
            $display("FAIL adj_bad_hour: got %0d:%0d:%0d err=%b, want 12:34:56 err=1",
                     hour, minute, second, adj_error);
        end
        adj_hour = 5'd1; adj_min = 6'd60; adj_sec = 6'd3;
        cycle();
        checks++;
        if ({hour, minute, second, adj_error} !== {5'd12, 6'd34, 6'd56, 1'b1}) begin
            failures++;
            $display("FAIL adj_bad_min: got %0d:%0d:%0d err=%b, want 12:34:56 err=1",
                     hour, minute, second, adj_error);
        end
        adjust_mode = 1'b0; tick = 1'b1;
        cycle();
        tick = 1'b0;
        checks++;
        if ({hour, minute, second, adj_error} !== {5'd12, 6'd34, 6'd57, 1'b1}) begin
            failures++;
            $display("FAIL adj_err_sticky: got %0d:%0d:%0d err=%b, want 12:34:57 err=1",
                     hour, minute, second, adj_error);
        end
        adjust_mode = 1'b1; tick = 1'b1;
        adj_hour = 5'd1; adj_min = 6'd2; adj_sec = 6'd3;
        cycle();
        cycle();
        adjust_mode = 1'b0; tick = 1'b0;
        checks++;
        if ({hour, minute, second, carry_min, carry_hour, carry_day, adj_error} !== {5'd1, 6'd2, 6'd3, 3'b000, 1'b0}) begin
            failures++;
            $display("FAIL adj_good: got %0d:%0d:%0d c=%b%b%b err=%b, want 1:2:3 c=000 err=0",
                     hour, minute, second, carry_min, carry_hour, carry_day, adj_error);
        end
    endtask

    task automatic test_back_to_back();
        load_time(5'd0, 6'd59, 6'd58);
        tick = 1'b1;
        cycle();
        checks++;
        if ({hour, minute, second, carry_min, carry_hour} !== {5'd0, 6'd59, 6'd59, 2'b00}) begin
            failures++;
            $display("FAIL b2b_1: got %0d:%0d:%0d c=%b%b, want 0:59:59 c=00",
                     hour, minute, second, carry_min, carry_hour);
        end
        cycle();
        checks++;
        if ({hour, minute, second, carry_min, carry_hour} !== {5'd1, 6'd0, 6'd0, 2'b11}) begin
            failures++;
            $display("FAIL b2b_2: got %0d:%0d:%0d c=%b%b, want 1:0:0 c=11",
                     hour, minute, second, carry_min, carry_hour);
        end
        cycle();
        tick = 1'b0;
        checks++;
        if ({hour, minute, second, carry_min, carry_hour} !== {5'd1, 6'd0, 6'd1, 2'b00}) begin
            failures++;
            $display("FAIL b2b_3: got %0d:%0d:%0d c=%b%b, want 1:0:1 c=00",
                     hour, minute, second, carry_min, carry_hour);
        end
    endtask

    task automatic test_reset_mid();
        load_time(5'd23, 6'd59, 6'd59);
        tick = 1'b1; rst = 1'b1;
        #1;
        checks++;
        if ({hour, minute, second, carry_day} !== 18'd0) begin
            failures++;
            $display("FAIL rst_async: got %0d:%0d:%0d cd=%b, want 0:0:0 cd=0",
                     hour, minute, second, carry_day);
        end
        cycle();
        checks++;
        if ({hour, minute, second, carry_min, carry_hour, carry_day} !== 20'd0) begin
            failures++;
            $display("FAIL rst_with_tick: got %0d:%0d:%0d c=%b%b%b, want 0:0:0 c=000",
                     hour, minute, second, carry_min, carry_hour, carry_day);
        end
        rst = 1'b0; tick = 1'b0;
        cycle();
        checks++;
        if (carry_day !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_day: got cd=%b, want 0", carry_day);
        end
        load_time(5'd23, 6'd59, 6'd59);
        do_tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({carry_min, carry_hour, carry_day} !== 3'b000) begin
            failures++;
            $display("FAIL rst_kill_carry: got c=%b%b%b, want 000", carry_min, carry_hour, carry_day);
        end
        cycle();
        rst = 1'b0;
    endtask

`ifdef TIME_12H_EN
    task automatic test_12h();
        logic [4:0] hv  [5] = '{5'd0, 5'd5, 5'd12, 5'd13, 5'd23};
        logic [4:0] exp [5] = '{5'd12, 5'd5, 5'd12, 5'd1, 5'd11};
        logic       epm [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            load_time(hv[i], 6'd0, 6'd0);
            checks++;
            if ({pm, 1'b0, hour12} !== {epm[i], exp[i]}) begin
                failures++;
                $display("FAIL map12[%0d]: got hour12=%0d pm=%b, want %0d pm=%b",
                         hv[i], hour12, pm, exp[i], epm[i]);
            end
        end
        load_time(5'd11, 6'd59, 6'd59);
        do_tick();
        checks++;
        if ({pm, hour12} !== {1'b1, 4'd12}) begin
            failures++;
            $display("FAIL map12_tick: got hour12=%0d pm=%b, want 12 pm=1", hour12, pm);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_day_rollover();
        test_hour_carry();
        test_adjust_error();
        test_back_to_back();
        test_reset_mid();
`ifdef TIME_12H_EN
        test_12h();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
